// File: rtl/pbs_pkg.sv
// Shared battle-system definitions: turn FSM states, datapath widths and
// trainer/target encodings.
package pbs_pkg;

  localparam int HP_W = 4;

  localparam logic ACTR_PLAYER = 1'b0;
  localparam logic ACTR_AI     = 1'b1;
  localparam logic TGT_PLAYER  = 1'b0;
  localparam logic TGT_AI      = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    PL_SETTLE,
    PL_APPLY,
    PL_CHECK,
    AI_SETTLE,
    AI_APPLY,
    AI_CHECK,
    OVER
  } pbs_turn_state_t;

  function automatic logic is_ai_state(pbs_turn_state_t s);
    return (s == AI_SETTLE) || (s == AI_APPLY) || (s == AI_CHECK);
  endfunction

  // A turn is in flight: GARO outputs must stay frozen.
  function automatic logic is_busy_state(pbs_turn_state_t s);
    return (s != IDLE) && (s != OVER);
  endfunction

endpackage

// File: rtl/pbs_settle_timer.sv
// 4-bit load/count-down timer; done is high while enabled and the count has
// reached zero, which ends the settle window.
module pbs_settle_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic       done_o
);

  logic [3:0] cnt_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 4'd0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != 4'd0)) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign done_o = en_i && (cnt_q == 4'd0);

endmodule

// File: rtl/pbs_turn_ctrl.sv
// Turn sequencer: player-then-AI turn order, accuracy roll, knockout detect
// and datapath HP re-initialisation on restart. All outputs are registered.
module pbs_turn_ctrl
  import pbs_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            move_valid,
  input  logic [1:0]      move_sel,
  input  logic            restart,
  input  logic [HP_W-1:0] p_hp,
  input  logic [HP_W-1:0] ai_hp,
  input  logic [3:0]      accu,
  input  logic [3:0]      accu_rng,
  output logic [1:0]      p_move,
  output logic            actr,
  output logic            target,
  output logic            stop,
  output logic            load_ai_hp,
  output logic            app_ai_dmg,
  output logic            app_pl_dmg,
  output logic            dp_rst_n,
  output logic            last_hit,
  output logic            game_over,
  output logic            winner,
  output logic [7:0]      turn_cnt
);

  // The timer is loaded on entry and counts the remaining settle cycles.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  pbs_turn_state_t state_q, state_d;
  logic [1:0] p_move_q, p_move_d;
  logic       actr_q, actr_d, target_q, target_d, stop_q, stop_d;
  logic       load_ai_hp_q, load_ai_hp_d;
  logic       app_ai_dmg_q, app_ai_dmg_d, app_pl_dmg_q, app_pl_dmg_d;
  logic       dp_rst_n_q, dp_rst_n_d;
  logic       last_hit_q, last_hit_d, game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic [7:0] turn_cnt_q, turn_cnt_d;
  logic       tmr_load, tmr_en, tmr_done, hit;

  assign tmr_en = (state_q == PL_SETTLE) || (state_q == AI_SETTLE);
  assign hit    = (accu_rng <= accu);

  pbs_settle_timer u_settle (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_LOAD),
    .en_i       (tmr_en),
    .done_o     (tmr_done)
  );

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_d      = state_q;
    p_move_d     = p_move_q;
    last_hit_d   = last_hit_q;
    winner_d     = winner_q;
    turn_cnt_d   = turn_cnt_q;
    load_ai_hp_d = 1'b0;
    app_ai_dmg_d = 1'b0;
    app_pl_dmg_d = 1'b0;
    dp_rst_n_d   = 1'b1;
    tmr_load     = 1'b0;

    unique case (state_q)
      IDLE: if (move_valid) begin
        p_move_d     = move_sel;
        load_ai_hp_d = 1'b1;
        tmr_load     = 1'b1;
        state_d      = PL_SETTLE;
      end
      PL_SETTLE: if (tmr_done) begin
        app_ai_dmg_d = hit;
        last_hit_d   = hit;
        state_d      = PL_APPLY;
      end
      PL_APPLY: state_d = PL_CHECK;
      PL_CHECK: if (ai_hp == '0) begin
        winner_d = 1'b0;
        state_d  = OVER;
      end else begin
        tmr_load = 1'b1;
        state_d  = AI_SETTLE;
      end
      AI_SETTLE: if (tmr_done) begin
        app_pl_dmg_d = hit;
        last_hit_d   = hit;
        state_d      = AI_APPLY;
      end
      AI_APPLY: state_d = AI_CHECK;
      AI_CHECK: if (p_hp == '0) begin
        winner_d = 1'b1;
        state_d  = OVER;
      end else begin
        if (turn_cnt_q != 8'hFF) turn_cnt_d = turn_cnt_q + 8'd1;
        state_d = IDLE;
      end
      OVER: state_d = OVER;
      default: state_d = IDLE;
    endcase

    // Restart pre-empts whatever the state machine decided this cycle.
    if (restart) begin
      state_d      = IDLE;
      p_move_d     = p_move_q;
      last_hit_d   = 1'b0;
      winner_d     = 1'b0;
      turn_cnt_d   = 8'd0;
      load_ai_hp_d = 1'b0;
      app_ai_dmg_d = 1'b0;
      app_pl_dmg_d = 1'b0;
      dp_rst_n_d   = 1'b0;
      tmr_load     = 1'b0;
    end

    actr_d      = is_ai_state(state_d) ? ACTR_AI : ACTR_PLAYER;
    target_d    = (is_busy_state(state_d) && !is_ai_state(state_d)) ? TGT_AI : TGT_PLAYER;
    stop_d      = is_busy_state(state_d);
    game_over_d = (state_d == OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      p_move_q     <= 2'd0;
      actr_q       <= ACTR_PLAYER;
      target_q     <= TGT_PLAYER;
      stop_q       <= 1'b0;
      load_ai_hp_q <= 1'b0;
      app_ai_dmg_q <= 1'b0;
      app_pl_dmg_q <= 1'b0;
      dp_rst_n_q   <= 1'b1;
      last_hit_q   <= 1'b0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      turn_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      p_move_q     <= p_move_d;
      actr_q       <= actr_d;
      target_q     <= target_d;
      stop_q       <= stop_d;
      load_ai_hp_q <= load_ai_hp_d;
      app_ai_dmg_q <= app_ai_dmg_d;
      app_pl_dmg_q <= app_pl_dmg_d;
      dp_rst_n_q   <= dp_rst_n_d;
      last_hit_q   <= last_hit_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      turn_cnt_q   <= turn_cnt_d;
    end
  end

  assign p_move     = p_move_q;
  assign actr       = actr_q;
  assign target     = target_q;
  assign stop       = stop_q;
  assign load_ai_hp = load_ai_hp_q;
  assign app_ai_dmg = app_ai_dmg_q;
  assign app_pl_dmg = app_pl_dmg_q;
  assign dp_rst_n   = dp_rst_n_q;
  assign last_hit   = last_hit_q;
  assign game_over  = game_over_q;
  assign winner     = winner_q;
  assign turn_cnt   = turn_cnt_q;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed bench for pbs_turn_ctrl with SETTLE_CYCLES = 2: a table of whole
// turns checked cycle by cycle, plus restart, saturation and reset sequences.
module tb_pbs_turn_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_sel = 2'd0;
  logic       restart = 1'b0;
  logic [3:0] p_hp = 4'd8, ai_hp = 4'd8, accu = 4'd0, accu_rng = 4'd0;
  logic [1:0] p_move;
  logic       actr, target, stop, load_ai_hp, app_ai_dmg, app_pl_dmg;
  logic       dp_rst_n, last_hit, game_over, winner;
  logic [7:0] turn_cnt;

  pbs_turn_ctrl #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .move_valid (move_valid),
    .move_sel   (move_sel),
    .restart    (restart),
    .p_hp       (p_hp),
    .ai_hp      (ai_hp),
    .accu       (accu),
    .accu_rng   (accu_rng),
    .p_move     (p_move),
    .actr       (actr),
    .target     (target),
    .stop       (stop),
    .load_ai_hp (load_ai_hp),
    .app_ai_dmg (app_ai_dmg),
    .app_pl_dmg (app_pl_dmg),
    .dp_rst_n   (dp_rst_n),
    .last_hit   (last_hit),
    .game_over  (game_over),
    .winner     (winner),
    .turn_cnt   (turn_cnt)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled mid-cycle.
  int ai_cnt = 0, pl_cnt = 0, both_cnt = 0;
  always @(negedge clk) begin
    if (app_ai_dmg) ai_cnt++;
    if (app_pl_dmg) pl_cnt++;
    if (app_ai_dmg && app_pl_dmg) both_cnt++;
  end

  int n_checks = 0;
  int n_errors = 0;
  int exp_tc = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ending: 0 = turn completes, 1 = AI knocked out at PL_CHECK, 2 = player knocked out
  typedef struct {
    logic [1:0] sel;
    logic [3:0] accu;
    logic [3:0] rng;
    logic [3:0] ai_hp;
    logic [3:0] p_hp;
    logic       exp_hit;
    int         ending;
  } vec_t;

  vec_t vecs[8];

  task automatic do_restart(input string tag);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    exp_tc = 0;
    check({tag, " dp_rst_n low"}, dp_rst_n, 1'b0);
    check({tag, " game_over clr"}, game_over, 1'b0);
    check({tag, " winner clr"}, winner, 1'b0);
    check({tag, " turn_cnt clr"}, turn_cnt, 8'd0);
    check({tag, " last_hit clr"}, last_hit, 1'b0);
    check({tag, " stop idle"}, stop, 1'b0);
    tick();
    check({tag, " dp_rst_n one cycle"}, dp_rst_n, 1'b1);
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int ai0, pl0;
    string t;
    v = vecs[i];
    t = $sformatf("v%0d", i);
    accu = v.accu; accu_rng = v.rng; ai_hp = v.ai_hp; p_hp = v.p_hp;
    ai0 = ai_cnt; pl0 = pl_cnt;
    move_sel = v.sel; move_valid = 1'b1;
    tick();                                   // cycle 1: PL_SETTLE
    move_valid = 1'b0; move_sel = ~v.sel;
    check({t, " load_ai_hp first"}, load_ai_hp, 1'b1);
    check({t, " pl stop"}, stop, 1'b1);
    check({t, " pl target"}, target, 1'b1);
    check({t, " pl actr"}, actr, 1'b0);
    tick();                                   // cycle 2
    check({t, " load_ai_hp once"}, load_ai_hp, 1'b0);
    check({t, " no early ai_dmg"}, app_ai_dmg, 1'b0);
    tick();                                   // cycle 3: PL_APPLY
    check({t, " app_ai_dmg"}, app_ai_dmg, v.exp_hit);
    check({t, " p_move"}, p_move, v.sel);
    tick();                                   // cycle 4: PL_CHECK
    check({t, " ai_dmg one cycle"}, app_ai_dmg, 1'b0);
    check({t, " last_hit pl"}, last_hit, v.exp_hit);
    tick();                                   // cycle 5
    if (v.ending == 1) begin
      check({t, " game_over"}, game_over, 1'b1);
      check({t, " winner pl"}, winner, 1'b0);
      check({t, " over stop"}, stop, 1'b0);
      check({t, " turn_cnt kept"}, turn_cnt, 8'(exp_tc));
      tick(); tick(); tick(); tick();
      check({t, " no ai strobes"}, 8'(pl_cnt - pl0), 8'd0);
      check({t, " still over"}, game_over, 1'b1);
    end else begin
      check({t, " ai actr"}, actr, 1'b1);
      check({t, " ai target"}, target, 1'b0);
      check({t, " ai stop"}, stop, 1'b1);
      tick();                                 // cycle 6
      check({t, " no early pl_dmg"}, app_pl_dmg, 1'b0);
      tick();                                 // cycle 7: AI_APPLY
      check({t, " app_pl_dmg"}, app_pl_dmg, v.exp_hit);
      tick();                                 // cycle 8: AI_CHECK
      check({t, " pl_dmg one cycle"}, app_pl_dmg, 1'b0);
      tick();                                 // cycle 9
      if (v.ending == 2) begin
        check({t, " game_over"}, game_over, 1'b1);
        check({t, " winner ai"}, winner, 1'b1);
        check({t, " turn_cnt kept"}, turn_cnt, 8'(exp_tc));
      end else begin
        exp_tc++;
        check({t, " back idle"}, stop, 1'b0);
        check({t, " idle actr"}, actr, 1'b0);
        check({t, " not over"}, game_over, 1'b0);
        check({t, " turn_cnt inc"}, turn_cnt, 8'(exp_tc));
      end
      check({t, " pl strobe count"}, 8'(pl_cnt - pl0), 8'(v.exp_hit));
    end
    check({t, " ai strobe count"}, 8'(ai_cnt - ai0), 8'(v.exp_hit));
  endtask

  task automatic quick_turn();
    move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    repeat (9) tick();
  endtask

  initial begin
    int ai0, pl0;
    //           sel   accu  rng   ai_hp p_hp  hit   ending
    vecs[0] = '{2'd2, 4'd9,  4'd5,  4'd7, 4'd8, 1'b1, 0};
    vecs[1] = '{2'd1, 4'd9,  4'd10, 4'd7, 4'd8, 1'b0, 0};
    vecs[2] = '{2'd3, 4'd4,  4'd4,  4'd5, 4'd6, 1'b1, 0};
    vecs[3] = '{2'd0, 4'd0,  4'd0,  4'd5, 4'd6, 1'b1, 0};
    vecs[4] = '{2'd1, 4'd15, 4'd15, 4'd2, 4'd1, 1'b1, 0};
    vecs[5] = '{2'd2, 4'd0,  4'd1,  4'd2, 4'd1, 1'b0, 0};
    vecs[6] = '{2'd3, 4'd9,  4'd5,  4'd0, 4'd4, 1'b1, 1};
    vecs[7] = '{2'd1, 4'd9,  4'd5,  4'd3, 4'd0, 1'b1, 2};

    tick(); tick();
    check("rst p_move", p_move, 2'd0);
    check("rst stop", stop, 1'b0);
    check("rst actr", actr, 1'b0);
    check("rst target", target, 1'b0);
    check("rst dp_rst_n", dp_rst_n, 1'b1);
    check("rst game_over", game_over, 1'b0);
    check("rst turn_cnt", turn_cnt, 8'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_vec(i);
    run_vec(6);
    do_restart("r6");
    run_vec(7);
    move_valid = 1'b1;                        // ignored while OVER
    tick();
    move_valid = 1'b0;
    tick();
    check("over ignores move", game_over, 1'b1);
    check("over no load", load_ai_hp, 1'b0);
    do_restart("r7");

    // move_valid during AI_SETTLE, then restart together with move_valid.
    accu = 4'd9; accu_rng = 4'd5; ai_hp = 4'd7; p_hp = 4'd7;
    move_sel = 2'd2; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    repeat (4) tick();                        // cycle 5: AI_SETTLE
    check("seqA in ai_settle", actr, 1'b1);
    move_sel = 2'd0; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    check("seqA mv ignored actr", actr, 1'b1);
    check("seqA mv ignored p_move", p_move, 2'd2);
    pl0 = pl_cnt;
    restart = 1'b1; move_valid = 1'b1; move_sel = 2'd1;
    tick();
    restart = 1'b0; move_valid = 1'b0;
    check("seqA dp_rst_n", dp_rst_n, 1'b0);
    check("seqA idle stop", stop, 1'b0);
    check("seqA idle actr", actr, 1'b0);
    check("seqA p_move kept", p_move, 2'd2);
    check("seqA no pl strobe", app_pl_dmg, 1'b0);
    tick();
    check("seqA move not taken", load_ai_hp, 1'b0);
    check("seqA dp_rst_n back", dp_rst_n, 1'b1);
    tick(); tick();
    check("seqA stays idle", stop, 1'b0);
    check("seqA pl strobe count", 8'(pl_cnt - pl0), 8'd0);

    // Miss-only turns until the counter saturates.
    accu = 4'd0; accu_rng = 4'd15; ai_hp = 4'd9; p_hp = 4'd9;
    ai0 = ai_cnt; pl0 = pl_cnt;
    for (int n = 1; n <= 256; n++) begin
      quick_turn();
      if (n == 254) check("sat 254", turn_cnt, 8'd254);
      if (n == 255) check("sat 255", turn_cnt, 8'd255);
    end
    check("sat hold 255", turn_cnt, 8'd255);
    check("sat no ai strobes", 8'(ai_cnt - ai0), 8'd0);
    check("sat no pl strobes", 8'(pl_cnt - pl0), 8'd0);
    check("sat last_hit miss", last_hit, 1'b0);

    // rst during PL_SETTLE, with restart also high: rst wins.
    accu = 4'd9; accu_rng = 4'd5;
    move_sel = 2'd3; move_valid = 1'b1;
    tick();
    move_valid = 1'b0;
    check("seqC in pl_settle", load_ai_hp, 1'b1);
    ai0 = ai_cnt;
    rst = 1'b0; restart = 1'b1;
    tick();
    rst = 1'b1; restart = 1'b0;
    check("seqC p_move", p_move, 2'd0);
    check("seqC stop", stop, 1'b0);
    check("seqC target", target, 1'b0);
    check("seqC load_ai_hp", load_ai_hp, 1'b0);
    check("seqC dp_rst_n", dp_rst_n, 1'b1);
    check("seqC last_hit", last_hit, 1'b0);
    check("seqC turn_cnt", turn_cnt, 8'd0);
    tick();
    check("seqC no restart pulse", dp_rst_n, 1'b1);
    tick(); tick(); tick();
    check("seqC no strobe", 8'(ai_cnt - ai0), 8'd0);
    check("seqC idle", stop, 1'b0);
    check("one strobe per cycle", 8'(both_cnt), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
